regfile_write_arbiter: RTL

//  Shares the single write port of the 32x32 register file between NUM_REQ writeback sources (e.g. ALU, load unit).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_write_arbiter_if.sv | 25 ++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 19 +
 rtl/regfile_write_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file geometry, write-request record and shared helpers.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

    // One-hot of a register index with the hard-wired zero register masked out.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        return (NUM_REGS'(1) << a) & ~(NUM_REGS'(1) << ZERO_REG);
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback request bus and register-file write port.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic flush;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic reg_write;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic [31:0] pending_mask;

    modport master (
        output flush, req_valid, req_reg, req_data,
        input req_ready, reg_write, write_register, write_data, pending_mask
    );
    modport slave (
        input flush, req_valid, req_reg, req_data,
        output req_ready, reg_write, write_register, write_data, pending_mask
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr+1 with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W = $clog2(NUM_REQ)
) (
    input logic [NUM_REQ-1:0] req,
    input logic [PTR_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant
);
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick;

    // Requests strictly above ptr take priority; otherwise wrap to the lowest one.
    always_comb begin
        upper = req & ~((NUM_REQ'(2) << ptr) - NUM_REQ'(1));
        pick = |upper ? upper : req;
        grant = pick & (~pick + NUM_REQ'(1));
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: per-source one-entry buffers drained round-robin into the
// register-file write port, with a mask of registers that still have writes in flight.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input logic clock,
    input logic reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } hold_t;

    hold_t hold [NUM_REQ];
    hold_t sel;
    logic [NUM_REQ-1:0] hold_valid;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] take;
    logic [PTR_W-1:0] rr;
    logic [PTR_W-1:0] gidx;
    logic [31:0] mask;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(hold_valid),
        .ptr(rr),
        .grant(grant)
    );

    // Ready depends only on state and flush, so a granted buffer can refill in the same cycle.
    assign bus.req_ready = {NUM_REQ{!bus.flush}} & (~hold_valid | grant);
    assign take = bus.req_valid & bus.req_ready;

    always_comb begin
        gidx = '0;
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx = PTR_W'(i);
                sel = hold[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take[i]) hold[i] <= {bus.req_reg[i*ADDR_W +: ADDR_W], bus.req_data[i*DATA_W +: DATA_W]};
        end
    end

    // Flush drops buffers and the next stage load, but leaves rr and the last written index/data alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= '0;
            rr <= PTR_W'(NUM_REQ - 1);
            bus.reg_write <= 1'b0;
            bus.write_register <= '0;
            bus.write_data <= '0;
        end else if (bus.flush) begin
            hold_valid <= '0;
            bus.reg_write <= 1'b0;
        end else begin
            hold_valid <= (hold_valid & ~grant) | take;
            bus.reg_write <= |grant && sel.addr != ADDR_W'(ZERO_REG);
            if (|grant) begin
                rr <= gidx;
                bus.write_register <= sel.addr;
                bus.write_data <= sel.data;
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hold_valid[i]) mask = mask | reg_onehot(REG_ADDR_W'(hold[i].addr));
        end
        if (bus.reg_write) mask = mask | reg_onehot(REG_ADDR_W'(bus.write_register));
    end

    assign bus.pending_mask = mask;
endmodule
